// File: rtl/usb_pkt_buffer_if.sv
// usb_pkt_buffer_if: write/commit/abort and read bus of the USB packet buffer
interface usb_pkt_buffer_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64
);
  localparam int OCC_W = $clog2(DEPTH) + 1;
  logic              clear;
  logic              store;
  logic [DATA_W-1:0] wr_data;
  logic              wr_commit;
  logic              wr_abort;
  logic              get;
  logic [DATA_W-1:0] rd_data;
  logic [OCC_W-1:0]  buff_occ;
  logic [OCC_W-1:0]  pend_occ;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;
  modport master (
    output clear, store, wr_data, wr_commit, wr_abort, get,
    input  rd_data, buff_occ, pend_occ, full, empty, overflow, underflow
  );
  modport slave (
    input  clear, store, wr_data, wr_commit, wr_abort, get,
    output rd_data, buff_occ, pend_occ, full, empty, overflow, underflow
  );
endinterface

// File: rtl/usb_pkt_buffer.sv
// usb_pkt_buffer: packet FIFO with tentative writes, commit and abort; USB_PKT_BUF_FWFT_EN selects first-word-fall-through reads
module usb_pkt_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic            clk,
  input  logic            rst,
  usb_pkt_buffer_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int AW    = OCC_W - 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [OCC_W-1:0]  rptr, cptr, wptr;
  logic [OCC_W-1:0]  rptr_nxt, cptr_nxt, wptr_nxt, wptr_inc;
  logic              acc_store, acc_get;
  logic              overflow, underflow;
  assign bus.buff_occ  = cptr - rptr;
  assign bus.pend_occ  = wptr - cptr;
  assign bus.full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign bus.empty     = cptr == rptr;
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;
  // Next pointers: clear beats everything, abort beats commit, commit includes this cycle's store
  always_comb begin
    acc_store = bus.store && !bus.full;
    acc_get   = bus.get && !bus.empty;
    wptr_inc  = wptr + OCC_W'(acc_store);
    wptr_nxt  = bus.clear ? '0 : bus.wr_abort ? cptr : wptr_inc;
    cptr_nxt  = bus.clear ? '0 : bus.wr_abort ? cptr : bus.wr_commit ? wptr_inc : cptr;
    rptr_nxt  = bus.clear ? '0 : rptr + OCC_W'(acc_get);
  end
  // Pointer and sticky error flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr      <= '0;
      cptr      <= '0;
      wptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rptr      <= rptr_nxt;
      cptr      <= cptr_nxt;
      wptr      <= wptr_nxt;
      overflow  <= !bus.clear && (overflow || (bus.store && bus.full));
      underflow <= !bus.clear && (underflow || (bus.get && bus.empty));
    end
  end
  // Storage array, deliberately not reset; an aborted write lands beyond wptr and is never read
  always_ff @(posedge clk) begin
    if (acc_store && !bus.clear) mem[wptr[AW-1:0]] <= bus.wr_data;
  end
`ifdef USB_PKT_BUF_FWFT_EN
  assign bus.rd_data = bus.empty ? '0 : mem[rptr[AW-1:0]];
`else
  logic [DATA_W-1:0] rd_q;
  assign bus.rd_data = rd_q;
  // Registered read data loads on an accepted get and holds otherwise, including across clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= '0;
    else if (acc_get && !bus.clear) rd_q <= mem[rptr[AW-1:0]];
  end
`endif
endmodule

// File: tb/tb_usb_pkt_buffer.sv
// tb_usb_pkt_buffer: queue-model scoreboard bench for usb_pkt_buffer in registered read mode
module tb_usb_pkt_buffer;
  localparam int DEPTH = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   ov = 1'b0;
  bit   uf = 1'b0;
  logic [7:0] mq[$];
  logic [7:0] pq[$];
  logic [7:0] saved;
  usb_pkt_buffer_if #(.DATA_W(8), .DEPTH(DEPTH)) bus ();
  usb_pkt_buffer #(.DATA_W(8), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_state();
    chk("buff_occ", 32'(bus.buff_occ), mq.size());
    chk("pend_occ", 32'(bus.pend_occ), pq.size());
    chk("full", 32'(bus.full), 32'(mq.size() + pq.size() == DEPTH));
    chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
    chk("overflow", 32'(bus.overflow), 32'(ov));
    chk("underflow", 32'(bus.underflow), 32'(uf));
  endtask
  task automatic step(input logic st, input logic [7:0] d, input logic cm, input logic ab,
                      input logic gt, input logic cl);
    bit fm, em, rd_chk;
    logic [7:0] rexp;
    fm = (mq.size() + pq.size()) == DEPTH;
    em = mq.size() == 0;
    rd_chk = 1'b0;
    rexp = '0;
    bus.store = st; bus.wr_data = d; bus.wr_commit = cm;
    bus.wr_abort = ab; bus.get = gt; bus.clear = cl;
    @(posedge clk); #1;
    bus.store = 0; bus.wr_commit = 0; bus.wr_abort = 0; bus.get = 0; bus.clear = 0;
    if (cl) begin
      mq.delete(); pq.delete(); ov = 0; uf = 0;
    end else begin
      if (gt) begin
        if (em) uf = 1;
        else begin rexp = mq.pop_front(); rd_chk = 1; end
      end
      if (st) begin
        if (fm) ov = 1;
        else pq.push_back(d);
      end
      if (ab) pq.delete();
      else if (cm) begin
        foreach (pq[i]) mq.push_back(pq[i]);
        pq.delete();
      end
    end
    if (rd_chk) chk("rd_data", 32'(bus.rd_data), 32'(rexp));
    check_state();
  endtask
  initial begin
    bus.clear = 0; bus.store = 0; bus.wr_data = 0; bus.wr_commit = 0; bus.wr_abort = 0; bus.get = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_rd_data", 32'(bus.rd_data), 0);
    check_state();
    step(1, 8'hDE, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("rd_de", 32'(bus.rd_data), 32'h0DE);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h50 + i), 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 8'(i), i == DEPTH - 1, 0, 0, 0);
    chk("fill_full", 32'(bus.full), 1);
    step(1, 8'hAA, 1, 0, 0, 0);
    chk("fill_ovf", 32'(bus.overflow), 1);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 8'(8'hA0 + i), i == 2, 0, 0, 0);
    step(1, 8'hB0, 0, 0, 0, 0);
    step(1, 8'hB1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    step(1, 8'h00, 1, 0, 0, 0);
    for (int i = 1; i <= 100; i++) step(1, 8'(i), 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 8'(8'hC0 + i), i == 9, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    saved = bus.rd_data;
    step(1, 8'hEE, 1, 0, 1, 1);
    chk("clear_rd_hold", 32'(bus.rd_data), 32'(saved));
    for (int i = 0; i < 3; i++) step(1, 8'(8'hD0 + i), i == 1, 0, 0, 0);
    #2 rst = 1;
    #1;
    mq.delete(); pq.delete(); ov = 0; uf = 0;
    chk("rst_mid_rd_data", 32'(bus.rd_data), 0);
    check_state();
    @(posedge clk); #1 rst = 0;
    step(0, 0, 0, 0, 1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
